riscv_multicycle_core: RTL and testbench
========================================

# riscv_multicycle_core

Parametrised multi-cycle RV32I-subset core: controller FSM, register file, ALU and PC logic in one block, sharing a single instruction/data memory port with a req/ready handshake. It generalises the single-cycle processor top. Split instruction/data memories with zero-latency reads become one unified memory that may insert wait states. The block adds a selectable register-file depth, a configurable reset vector, an illegal-instruction halt and a retire strobe.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NREGS, 32: architectural registers, 32 (RV32I) or 16 (RV32E); rs/rd indices ≥ NREGS are illegal.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- mem_req  output  1  memory request; held high until the access completes.
- mem_we  output  1  1 = word store, 0 = word load/fetch; valid while mem_req.
- mem_addr  output  32  byte address, word aligned; valid while mem_req.
- mem_wdata  output  32  store data; valid while mem_req && mem_we.
- mem_rdata  input  32  load/fetch data; sampled in the cycle mem_ready is high.
- mem_ready  input  1  access completes in any cycle with mem_req && mem_ready; may be high in the same cycle mem_req rises.
- pc  output  32  address of the instruction currently in flight.
- retire  output  1  one-cycle pulse when an instruction completes.
- halted  output  1  sticky; set on illegal instruction.

## Operation
- Supported: lw, sw, add, sub, and, or, slt (R-type), addi, andi, ori, slti, beq, jal. Any other opcode/funct combination, and any register index ≥ NREGS, is illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ready, latch instr and go to DECODE.
- DECODE: read rs1/rs2 into A/B, sign-extend the immediate, compute branch/jump target = pc + imm. Illegal goes to HALT; otherwise go to EXEC.
- EXEC:
  - ALU ops and lw/sw address: result = A op (B or imm). slt is signed. sub is two's complement, with wrap-around and no overflow flag.
  - beq: pc ← target if A==B, else pc+4; retire; go to FETCH.
  - jal: result ← pc+4; go to WB.
  - lw/sw: go to MEM. ALU ops: go to WB.
- MEM: mem_req=1, mem_addr=result with addr[1:0] forced to 0, mem_we=1 for sw with wdata=B. On ready: lw latches rdata and goes to WB; sw sets pc←pc+4, retires and goes to FETCH.
- WB: rd ← result (or load data); pc ← target for jal, else pc+4; retire; go to FETCH.
- x0 reads as 0; writes to x0 are discarded.
- HALT: mem_req=0, halted=1, pc frozen. Stays until reset.

## Timing
- Reset (any state, including mid-access with mem_req high):
  - Next cycle: state=FETCH, pc=RESET_PC, all registers 0, halted=0, retire=0.
  - mem_req=0 while reset is high; an abandoned access is not completed.
- mem_req, mem_we, mem_addr and mem_wdata are decoded from state and held stable across wait cycles. mem_req never drops before ready.
- Cycles per instruction with zero wait states (ready in the request cycle):
  - ALU op, jal: 4 (FETCH, DECODE, EXEC, WB).
  - lw: 5. sw: 4. beq: 3.
  - Each wait cycle on either access adds 1.
- retire is high in the last cycle of the instruction. pc updates at that edge.
- Register write and the following FETCH do not overlap, so no hazards exist.

## Test plan
- Reset: hold reset 2 cycles with RESET_PC=32'h100. Required: mem_req=0 throughout reset; next cycle mem_addr=32'h100, mem_req=1, halted=0.
- ALU sequence: 00500093 (addi x1,x0,5), then 00108133 (add x2,x1,x1). Required: x2=10; retire every 4 cycles; pc advances by 4 per instruction.
- Store/load with memory ready delayed 3 cycles per access: 00202423 (sw x2,8(x0)), then 00802183 (lw x3,8(x0)). Required: store presents addr 8, wdata 10, we=1, held steady for 4 cycles; x3=10; the lw takes 5+6 cycles.
- Branch/jump at pc=0x20:
  - 00108463 (beq x1,x1,+8) → next fetch at 0x28, 3 cycles.
  - 010000EF (jal x1,+16) at 0x28 → x1=0x2C, next fetch at 0x38.
- Illegal instruction: fetch 00000000. Required: halted=1 after DECODE, mem_req stays 0, no retire; a reset pulse restarts at RESET_PC.
- NREGS=16: addi with rd=x20. Required: halt; no register written.

Source files
------------

// File: rtl/riscv_multicycle_core_if.sv
// Unified instruction/data memory port with a req/ready handshake.
// The core holds req and the address/data fields until the memory raises ready.
// The memory may raise ready in the same cycle req rises, or insert wait states.
interface riscv_multicycle_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I-subset core sharing one memory port for fetch and load/store.
// Latency: beq 3, ALU/jal/sw 4, lw 5 cycles, plus one per memory wait cycle.
// Backpressure: mem_req and its fields stay stable until mem_ready; illegal instr halts.
module riscv_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  riscv_multicycle_core_if.master  mem,
  output logic [31:0]              pc,
  output logic                     retire,
  output logic                     halted
);
  localparam int IW = $clog2(NREGS);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] instr, a, b, imm, target, result;
  logic [31:0] regs [NREGS];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        is_r, is_i, is_lw, is_sw, is_beq, is_jal;
  logic        use_rs1, use_rs2, use_rd, legal;
  logic [31:0] imm_dec, rs1_val, rs2_val, op2, alu_out;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Register indices beyond the configured file size are architecturally illegal.
  function automatic logic reg_ok(input logic [4:0] idx);
    return int'({27'b0, idx}) < NREGS;
  endfunction

  // Instruction classification and legality, from the latched instruction word.
  always_comb begin
    is_r   = (opcode == 7'b0110011) &&
             ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b111 ||
                                        funct3 == 3'b110 || funct3 == 3'b010)) ||
              (funct7 == 7'b0100000 && funct3 == 3'b000));
    is_i   = (opcode == 7'b0010011) &&
             (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110 || funct3 == 3'b010);
    is_lw  = (opcode == 7'b0000011) && (funct3 == 3'b010);
    is_sw  = (opcode == 7'b0100011) && (funct3 == 3'b010);
    is_beq = (opcode == 7'b1100011) && (funct3 == 3'b000);
    is_jal = (opcode == 7'b1101111);
    use_rs1 = is_r | is_i | is_lw | is_sw | is_beq;
    use_rs2 = is_r | is_sw | is_beq;
    use_rd  = is_r | is_i | is_lw | is_jal;
    legal   = (is_r | is_i | is_lw | is_sw | is_beq | is_jal) &&
              !(use_rs1 && !reg_ok(rs1)) &&
              !(use_rs2 && !reg_ok(rs2)) &&
              !(use_rd  && !reg_ok(rd));
  end

  // Immediate extraction and register-file read ports (x0 and out-of-range read as 0).
  always_comb begin
    imm_dec = {{20{instr[31]}}, instr[31:20]};
    if (is_sw)
      imm_dec = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    else if (is_beq)
      imm_dec = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    else if (is_jal)
      imm_dec = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && reg_ok(rs1)) rs1_val = regs[rs1[IW-1:0]];
    if (rs2 != 5'd0 && reg_ok(rs2)) rs2_val = regs[rs2[IW-1:0]];
  end

  // ALU: loads/stores always add; R-type uses B, I-type uses the immediate.
  always_comb begin
    op2     = is_r ? b : imm;
    alu_out = a + op2;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_out = (is_r && funct7[5]) ? a - op2 : a + op2;
        3'b111:  alu_out = a & op2;
        3'b110:  alu_out = a | op2;
        3'b010:  alu_out = {31'b0, $signed(a) < $signed(op2)};
        default: alu_out = a + op2;
      endcase
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Controller next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (mem.mem_ready) state_nxt = DECODE;
      DECODE:  state_nxt = legal ? EXEC : HALT;
      EXEC:    state_nxt = is_beq ? FETCH : ((is_lw || is_sw) ? MEM : WB);
      MEM:     if (mem.mem_ready) state_nxt = is_lw ? WB : FETCH;
      WB:      state_nxt = FETCH;
      default: state_nxt = HALT;
    endcase
  end

  // Controller outputs; the memory request is suppressed while reset is asserted.
  always_comb begin
    mem.mem_req   = !reset && (state == FETCH || state == MEM);
    mem.mem_we    = (state == MEM) && is_sw;
    mem.mem_addr  = (state == MEM) ? {result[31:2], 2'b00} : pc;
    mem.mem_wdata = b;
    retire        = !reset && ((state == EXEC && is_beq) ||
                               (state == MEM && mem.mem_ready && is_sw) ||
                               (state == WB));
    halted        = (state == HALT);
  end

  // Datapath registers: instruction latch, operands, result, PC and register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      instr  <= '0;
      a      <= '0;
      b      <= '0;
      imm    <= '0;
      target <= '0;
      result <= '0;
      for (int i = 0; i < NREGS; i++) regs[IW'(i)] <= '0;
    end else begin
      case (state)
        FETCH: if (mem.mem_ready) instr <= mem.mem_rdata;
        DECODE: begin
          a      <= rs1_val;
          b      <= rs2_val;
          imm    <= imm_dec;
          target <= pc + imm_dec;
        end
        EXEC: begin
          result <= is_jal ? pc + 32'd4 : alu_out;
          if (is_beq) pc <= (a == b) ? target : pc + 32'd4;
        end
        MEM: if (mem.mem_ready) begin
          if (is_lw) result <= mem.mem_rdata;
          else       pc     <= pc + 32'd4;
        end
        WB: begin
          if (use_rd && rd != 5'd0) regs[rd[IW-1:0]] <= result;
          pc <= is_jal ? target : pc + 32'd4;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Bench for riscv_multicycle_core: random programs against an ISA-level model.
// Memory responder inserts fixed or random wait states on every access.
// A monitor pops expected retire events and compares pc, stores and cycle counts.
module tb_riscv_multicycle_core;
  localparam logic [31:0] RST_PC = 32'h100;
  localparam int          NR     = 16;
  localparam int          MW     = 1024;

  typedef struct packed {
    logic [31:0] pc;
    logic        st;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [7:0]  cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        retire, halted;

  riscv_multicycle_core_if bus();

  riscv_multicycle_core #(.RESET_PC(RST_PC), .NREGS(NR)) dut (
    .clk(clk), .reset(reset), .mem(bus.master),
    .pc(pc), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MW];
  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wait_mode = 0;
  int          waits = 0;
  int          prog_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] o, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {o[12], o[10:5], rs2, rs1, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] o, input logic [4:0] rd);
    return {o[20], o[10:1], o[11], o[19:12], rd, 7'b1101111};
  endfunction

  task automatic put(input logic [31:0] w);
    mem[(RST_PC >> 2) + 32'(prog_len)] = w;
    prog_len++;
  endtask

  // One random legal instruction at body index i; branches only jump forward.
  task automatic gen_instr(input int i, input int n);
    int          kind, k;
    logic [2:0]  f3;
    logic [4:0]  ra, rb, rc;
    logic [11:0] im;
    logic [2:0]  ftab [4];
    ftab = '{3'b000, 3'b111, 3'b110, 3'b010};
    kind = $urandom_range(0, 9);
    ra = 5'($urandom_range(0, NR - 1));
    rb = 5'($urandom_range(0, NR - 1));
    rc = 5'($urandom_range(0, NR - 1));
    f3 = ftab[$urandom_range(0, 3)];
    k  = $urandom_range(1, (n - i) < 4 ? (n - i) : 4);
    im = 12'h400 + 12'($urandom_range(0, 127) * 4) + 12'($urandom_range(0, 3));
    case (kind)
      0, 1, 2: put(enc_r((f3 == 3'b000 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                         rb, ra, f3, rc));
      5:       put(enc_i(im, 5'd0, 3'b010, rc, 7'b0000011));
      6:       put(enc_s(im, rb, 5'd0));
      7:       put(enc_b(13'(4 * k), ra, ($urandom_range(0, 1) == 1) ? ra : rb));
      8:       put(enc_j(21'(4 * k), rc));
      default: put(enc_i(12'($urandom), ra, f3, rc, 7'b0010011));
    endcase
  endtask

  task automatic build_program(input int r);
    int n;
    for (int i = 0; i < MW; i++) mem[i] = $urandom;
    prog_len = 0;
    if (r == 0) begin
      put(32'h00500093); put(32'h00108133); put(32'h00202423); put(32'h00802183);
      put(32'h00108463); put(32'h00100213); put(32'h010000EF);
      put(32'h00128293); put(32'h00128293); put(32'h00128293);
    end else begin
      n = 20 + $urandom_range(0, 15);
      for (int i = 0; i < n; i++) gen_instr(i, n);
    end
    for (int x = 1; x < NR; x++) put(enc_s(12'h600 + 12'(4 * x), 5'(x), 5'd0));
    case (r % 5)
      0: put(32'h0000_0000);
      1: put(enc_i(12'd1, 5'd0, 3'b000, 5'd20, 7'b0010011));
      2: put(enc_r(7'h00, 5'd17, 5'd0, 3'b000, 5'd1));
      3: put(enc_r(7'h20, 5'd1, 5'd1, 3'b111, 5'd1));
      default: put(32'h0000_10B7);
    endcase
  endtask

  // ---------------- ISA-level reference model ----------------
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic sub,
                                      input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'b000:  return sub ? x - y : x + y;
      3'b111:  return x & y;
      3'b110:  return x | y;
      default: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic model_run(output logic [31:0] hpc);
    logic [31:0] x [32];
    logic [31:0] mm [MW];
    logic [31:0] mpc, ins, va, vb, v, npc, ad, iI, iS, iB, iJ;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, s1, s2;
    logic        ok, wr;
    ev_t         e;
    for (int i = 0; i < MW; i++) mm[i] = mem[i];
    for (int i = 0; i < 32; i++) x[i] = '0;
    mpc = RST_PC;
    hpc = 32'hFFFF_FFFF;
    for (int step = 0; step < 1000; step++) begin
      ins = mm[mpc[11:2]];
      op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
      s1 = ins[19:15]; s2 = ins[24:20]; f7 = ins[31:25];
      iI = {{20{ins[31]}}, ins[31:20]};
      iS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      iB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      iJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      case (op)
        7'h33: ok = ((f7 == 7'h00 && f3 inside {3'd0, 3'd7, 3'd6, 3'd2}) ||
                     (f7 == 7'h20 && f3 == 3'd0)) && s1 < NR && s2 < NR && rd < NR;
        7'h13: ok = (f3 inside {3'd0, 3'd7, 3'd6, 3'd2}) && s1 < NR && rd < NR;
        7'h03: ok = f3 == 3'd2 && s1 < NR && rd < NR;
        7'h23: ok = f3 == 3'd2 && s1 < NR && s2 < NR;
        7'h63: ok = f3 == 3'd0 && s1 < NR && s2 < NR;
        7'h6F: ok = rd < NR;
        default: ok = 1'b0;
      endcase
      if (!ok) begin
        hpc = mpc;
        break;
      end
      va = x[s1]; vb = x[s2];
      e = '{pc: mpc, st: 1'b0, sa: 32'd0, sd: 32'd0, cyc: 8'd4};
      npc = mpc + 32'd4; wr = 1'b0; v = '0;
      case (op)
        7'h33: begin v = alu(f3, f7[5], va, vb); wr = 1'b1; end
        7'h13: begin v = alu(f3, 1'b0, va, iI); wr = 1'b1; end
        7'h03: begin ad = (va + iI) & ~32'd3; v = mm[ad[11:2]]; wr = 1'b1; e.cyc = 8'd5; end
        7'h23: begin
          ad = (va + iS) & ~32'd3; mm[ad[11:2]] = vb;
          e.st = 1'b1; e.sa = ad; e.sd = vb;
        end
        7'h63: begin if (va == vb) npc = mpc + iB; e.cyc = 8'd3; end
        default: begin v = mpc + 32'd4; wr = 1'b1; npc = mpc + iJ; end
      endcase
      if (wr && rd != 5'd0) x[rd] = v;
      exp_q.push_back(e);
      mpc = npc;
    end
  endtask

  // ---------------- memory responder (after reset updates, before the monitor) ----------------
  initial begin : responder
    logic       busy;
    int         wleft;
    logic [9:0] idx;
    busy = 1'b0; wleft = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset || !bus.mem_req) begin
        bus.mem_ready = 1'b0;
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy  = 1'b1;
          wleft = (wait_mode < 0) ? $urandom_range(0, 3) : wait_mode;
        end
        if (wleft == 0) begin
          idx = bus.mem_addr[11:2];
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem[idx];
          if (bus.mem_we) mem[idx] = bus.mem_wdata;
          busy = 1'b0;
        end else begin
          bus.mem_ready = 1'b0;
          wleft--;
          waits++;
        end
      end
    end
  end

  // ---------------- monitor: handshake stability and retire scoreboard ----------------
  initial begin : monitor
    int          cnt;
    logic        pend, hold_bad, st_seen, p_we;
    logic [31:0] p_addr, p_wd, st_a, st_d;
    ev_t         e;
    cnt = 0; pend = 0; hold_bad = 0; st_seen = 0;
    p_we = 0; p_addr = '0; p_wd = '0; st_a = '0; st_d = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0; waits = 0; pend = 0; hold_bad = 0; st_seen = 0;
      end else begin
        if (pend && (!bus.mem_req || bus.mem_we !== p_we || bus.mem_addr !== p_addr ||
                     (p_we && bus.mem_wdata !== p_wd)))
          hold_bad = 1'b1;
        if (bus.mem_req && bus.mem_ready) begin
          chk("req_hold_stable", 32'(hold_bad), 32'd0);
          chk("addr_align", 32'(bus.mem_addr[1:0]), 32'd0);
          hold_bad = 1'b0; pend = 1'b0;
          if (bus.mem_we) begin
            st_seen = 1'b1; st_a = bus.mem_addr; st_d = bus.mem_wdata;
          end
        end else if (bus.mem_req) begin
          pend = 1'b1; p_we = bus.mem_we; p_addr = bus.mem_addr; p_wd = bus.mem_wdata;
        end else begin
          pend = 1'b0;
        end
        if (!halted) cnt++;
        if (retire) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_retire: got retire at pc %h expected none", pc);
          end else begin
            e = exp_q.pop_front();
            chk("retire_pc", pc, e.pc);
            chk("store_seen", 32'(st_seen), 32'(e.st));
            if (e.st && st_seen) begin
              chk("store_addr", st_a, e.sa);
              chk("store_data", st_d, e.sd);
            end
            chk("cycles", 32'(cnt - waits), 32'(e.cyc));
          end
          cnt = 0; waits = 0; st_seen = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset(input int n);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("reset_req_low", 32'(bus.mem_req), 32'd0);
      @(posedge clk);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_req", 32'(bus.mem_req), 32'd1);
    chk("post_reset_addr", bus.mem_addr, RST_PC);
    chk("post_reset_pc", pc, RST_PC);
    chk("post_reset_halted", 32'(halted), 32'd0);
    chk("post_reset_retire", 32'(retire), 32'd0);
  endtask

  initial begin : stim
    logic [31:0] hpc;
    int          n;
    reset = 1'b1;
    for (int r = 0; r < 7; r++) begin
      build_program(r);
      model_run(hpc);
      wait_mode = (r < 2) ? 3 : ((r == 2) ? 0 : -1);
      do_reset(2);
      if (r == 1) begin
        // abandon a stalled fetch with a reset pulse
        repeat (2) @(negedge clk);
        chk("abort_req_high", 32'(bus.mem_req), 32'd1);
        do_reset(1);
      end
      n = 0;
      while (!halted && n < 4000) begin
        @(negedge clk);
        n++;
      end
      chk("halt_reached", 32'(halted), 32'd1);
      repeat (4) @(negedge clk);
      chk("halted_sticky", 32'(halted), 32'd1);
      chk("halt_req_low", 32'(bus.mem_req), 32'd0);
      chk("halt_pc_frozen", pc, hpc);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
